// File: rtl/outputc.sv
// rtl/outputc.sv - output channel: round-robin packet arbiter with per-VC credit flow control (option macro: OUTPUTC_OREG_EN)
`ifndef DATAW
`define DATAW 31
`endif
`ifndef VCHW
`define VCHW 0
`endif
`ifndef VCH
`define VCH 1
`endif
`ifndef PORTW
`define PORTW 2
`endif
`ifndef TYPE_MSB
`define TYPE_MSB 31
`endif
`ifndef TYPE_LSB
`define TYPE_LSB 30
`endif
`ifndef TYPE_DATA
`define TYPE_DATA 2'b00
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 2'b01
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 2'b10
`endif
`ifndef TYPE_HEADTAIL
`define TYPE_HEADTAIL 2'b11
`endif

module outputc #(
    parameter int PCHID  = 0,
    parameter int CREDIT = 4
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [`DATAW:0]   idata_0,
    input  logic [`DATAW:0]   idata_1,
    input  logic [`DATAW:0]   idata_2,
    input  logic [`DATAW:0]   idata_3,
    input  logic [`DATAW:0]   idata_4,
    input  logic              ivalid_0,
    input  logic              ivalid_1,
    input  logic              ivalid_2,
    input  logic              ivalid_3,
    input  logic              ivalid_4,
    input  logic [`VCHW:0]    ivch_0,
    input  logic [`VCHW:0]    ivch_1,
    input  logic [`VCHW:0]    ivch_2,
    input  logic [`VCHW:0]    ivch_3,
    input  logic [`VCHW:0]    ivch_4,
    input  logic              req_0,
    input  logic              req_1,
    input  logic              req_2,
    input  logic              req_3,
    input  logic              req_4,
    input  logic [`PORTW:0]   port_0,
    input  logic [`PORTW:0]   port_1,
    input  logic [`PORTW:0]   port_2,
    input  logic [`PORTW:0]   port_3,
    input  logic [`PORTW:0]   port_4,
    output logic              grt_0,
    output logic              grt_1,
    output logic              grt_2,
    output logic              grt_3,
    output logic              grt_4,
    output logic [`DATAW:0]   odata,
    output logic              ovalid,
    output logic [`VCHW:0]    ovch,
    input  logic [`VCH:0]     iack,
    output logic [`VCH:0]     ordy,
    output logic [`VCH:0]     olck
);
    localparam int NIN = 5;
    localparam int NVC = `VCH + 1;
    localparam logic [`PORTW:0] PID  = PCHID[`PORTW:0];
    localparam logic [3:0]      CRED = 4'(CREDIT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_nxt;
    logic [2:0]      owner, owner_nxt;
    logic [2:0]      rr, rr_nxt;
    logic [NVC-1:0]  lck, lck_nxt;
    logic [3:0]      cnt [NVC];
    logic [3:0]      cnt_nxt [NVC];

    logic [`DATAW:0] data [NIN];
    logic [`VCHW:0]  vch  [NIN];
    logic [`PORTW:0] port [NIN];
    logic [NIN-1:0]  valid, req, elig, grt;

    logic            xfer;
    logic [2:0]      xidx;
    logic [`DATAW:0] xdata;
    logic [`VCHW:0]  xvch;
    logic [1:0]      xtype;

    logic [`DATAW:0] link_data;
    logic            link_valid;
    logic [`VCHW:0]  link_vch;

    assign data  = '{idata_0, idata_1, idata_2, idata_3, idata_4};
    assign vch   = '{ivch_0, ivch_1, ivch_2, ivch_3, ivch_4};
    assign port  = '{port_0, port_1, port_2, port_3, port_4};
    assign valid = {ivalid_4, ivalid_3, ivalid_2, ivalid_1, ivalid_0};
    assign req   = {req_4, req_3, req_2, req_1, req_0};
    assign {grt_4, grt_3, grt_2, grt_1, grt_0} = grt;

    // A VC is ready while it has at least one downstream slot; an input is eligible only then
    always_comb begin
        ordy = '0;
        elig = '0;
        for (int v = 0; v < NVC; v++) ordy[v] = (cnt[v] != 4'd0);
        for (int n = 0; n < NIN; n++) elig[n] = req[n] && (port[n] == PID) && ordy[vch[n]];
    end

    // Grant: round-robin search from rr when idle, only the packet owner when busy; nothing in reset
    always_comb begin
        logic found;
        int   idx;
        grt   = '0;
        found = 1'b0;
        idx   = 0;
        if (!rst_) begin
            if (state == IDLE) begin
                for (int k = 0; k < NIN; k++) begin
                    idx = (int'(rr) + k) % NIN;
                    if (!found && elig[idx]) begin
                        grt[idx] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end else begin
                for (int n = 0; n < NIN; n++)
                    if (int'(owner) == n && elig[n]) grt[n] = 1'b1;
            end
        end
    end

    // Select the transferring input (at most one grant exists, so at most one hit)
    always_comb begin
        xfer  = 1'b0;
        xidx  = 3'd0;
        xdata = '0;
        xvch  = '0;
        for (int n = 0; n < NIN; n++) begin
            if (grt[n] && valid[n]) begin
                xfer  = 1'b1;
                xidx  = 3'(n);
                xdata = data[n];
                xvch  = vch[n];
            end
        end
        xtype = xdata[`TYPE_MSB:`TYPE_LSB];
    end

    // Packet FSM next state: HEAD opens a packet, TAIL (or a lone HEADTAIL) closes it and advances rr
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr;
        lck_nxt   = lck;
        if (xfer) begin
            if (state == IDLE && xtype == `TYPE_HEAD) begin
                state_nxt     = BUSY;
                owner_nxt     = xidx;
                lck_nxt       = '0;
                lck_nxt[xvch] = 1'b1;
            end else if ((state == BUSY && xtype == `TYPE_TAIL) ||
                         (state == IDLE && xtype == `TYPE_HEADTAIL)) begin
                state_nxt = IDLE;
                lck_nxt   = '0;
                rr_nxt    = (xidx == 3'd4) ? 3'd0 : xidx + 3'd1;
            end
        end
    end

    // VC lock is visible from the HEAD transfer cycle itself until the TAIL has gone
    always_comb begin
        olck = lck;
        if (xfer && state == IDLE && xtype == `TYPE_HEAD) olck[xvch] = 1'b1;
    end

    // Credits: a transfer consumes a slot, iack returns one; simultaneous events cancel; full ignores iack
    always_comb begin
        for (int v = 0; v < NVC; v++) begin
            logic dec, inc;
            dec        = xfer && (int'(xvch) == v);
            inc        = iack[v] && (cnt[v] != CRED);
            cnt_nxt[v] = cnt[v];
            if (dec && !inc)      cnt_nxt[v] = cnt[v] - 4'd1;
            else if (inc && !dec) cnt_nxt[v] = cnt[v] + 4'd1;
        end
    end

    // State, owner, rr, lock and credit registers
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state <= IDLE;
            owner <= 3'd0;
            rr    <= 3'd0;
            lck   <= '0;
            for (int v = 0; v < NVC; v++) cnt[v] <= CRED;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            rr    <= rr_nxt;
            lck   <= lck_nxt;
            for (int v = 0; v < NVC; v++) cnt[v] <= cnt_nxt[v];
        end
    end

    assign link_valid = xfer;
    assign link_data  = xfer ? xdata : '0;
    assign link_vch   = xfer ? xvch  : '0;

`ifdef OUTPUTC_OREG_EN
    // Registered link: a flit transferred in cycle t is driven in cycle t+1
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            odata  <= '0;
            ovalid <= 1'b0;
            ovch   <= '0;
        end else begin
            odata  <= link_data;
            ovalid <= link_valid;
            ovch   <= link_vch;
        end
    end
`else
    assign odata  = link_data;
    assign ovalid = link_valid;
    assign ovch   = link_vch;
`endif

endmodule

// File: tb/tb_outputc.sv
// tb/tb_outputc.sv - self-checking bench for outputc: directed scenarios plus randomized traffic against a reference model
`ifndef DATAW
`define DATAW 31
`endif
`ifndef VCHW
`define VCHW 0
`endif
`ifndef VCH
`define VCH 1
`endif
`ifndef PORTW
`define PORTW 2
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 2'b01
`endif
`ifndef TYPE_DATA
`define TYPE_DATA 2'b00
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 2'b10
`endif
`ifndef TYPE_HEADTAIL
`define TYPE_HEADTAIL 2'b11
`endif

module tb_outputc;
    localparam int PCHID  = 2;
    localparam int CREDIT = 4;

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;
    logic [31:0] d  [5];
    logic [0:0]  vc [5];
    logic [2:0]  pt [5];
    logic [4:0]  iv, rq;
    logic [1:0]  iack;
    wire  [4:0]  grt;
    wire  [31:0] odata;
    wire         ovalid;
    wire  [0:0]  ovch;
    wire  [1:0]  ordy, olck;

    int nchk = 0;
    int nerr = 0;

    // reference model state
    int          m_busy, m_owner, m_rr;
    int          m_cnt [2];
    logic [1:0]  m_lck;
    logic [31:0] r_data;
    logic        r_valid;
    logic [0:0]  r_vch;

    // values observed at the last step
    logic [4:0]  s_grt;
    logic [1:0]  s_ordy, s_olck;
    logic        s_ovalid;
    int          s_xfer;

    outputc #(.PCHID(PCHID), .CREDIT(CREDIT)) dut (
        .clk(clk), .rst_(rst_),
        .idata_0(d[0]), .idata_1(d[1]), .idata_2(d[2]), .idata_3(d[3]), .idata_4(d[4]),
        .ivalid_0(iv[0]), .ivalid_1(iv[1]), .ivalid_2(iv[2]), .ivalid_3(iv[3]), .ivalid_4(iv[4]),
        .ivch_0(vc[0]), .ivch_1(vc[1]), .ivch_2(vc[2]), .ivch_3(vc[3]), .ivch_4(vc[4]),
        .req_0(rq[0]), .req_1(rq[1]), .req_2(rq[2]), .req_3(rq[3]), .req_4(rq[4]),
        .port_0(pt[0]), .port_1(pt[1]), .port_2(pt[2]), .port_3(pt[3]), .port_4(pt[4]),
        .grt_0(grt[0]), .grt_1(grt[1]), .grt_2(grt[2]), .grt_3(grt[3]), .grt_4(grt[4]),
        .odata(odata), .ovalid(ovalid), .ovch(ovch),
        .iack(iack), .ordy(ordy), .olck(olck)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        for (int i = 0; i < 5; i++) begin
            d[i] = '0; vc[i] = '0; pt[i] = '0;
        end
        iv = '0; rq = '0; iack = '0;
    endtask

    function automatic bit model_elig(int i);
        return rq[i] && (int'(pt[i]) == PCHID) && (m_cnt[vc[i]] > 0);
    endfunction

    function automatic int model_grant();
        int g = -1;
        if (m_busy != 0) begin
            if (model_elig(m_owner)) g = m_owner;
        end else begin
            for (int k = 4; k >= 0; k--)
                if (model_elig((m_rr + k) % 5)) g = (m_rr + k) % 5;
        end
        return g;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_rr = 0; m_lck = '0;
        m_cnt[0] = CREDIT; m_cnt[1] = CREDIT;
        r_data = '0; r_valid = 1'b0; r_vch = '0;
    endtask

    // one clock cycle: check outputs at the falling edge, then advance the model past the rising edge
    task automatic step();
        int          g;
        bit          xf;
        logic [1:0]  ty, lk;
        logic [31:0] ed;
        logic [0:0]  evc;
        @(negedge clk);
        g   = model_grant();
        xf  = (g >= 0) && iv[g];
        ty  = xf ? d[g][31:30] : 2'b00;
        lk  = m_lck;
        if (xf && m_busy == 0 && ty == `TYPE_HEAD) lk[vc[g]] = 1'b1;
        ed  = xf ? d[g] : 32'd0;
        evc = xf ? vc[g] : 1'b0;
        check("grt", {27'd0, grt}, (g >= 0) ? (32'd1 << g) : 32'd0);
        check("ordy", {30'd0, ordy}, {30'd0, m_cnt[1] != 0, m_cnt[0] != 0});
        check("olck", {30'd0, olck}, {30'd0, lk});
`ifdef OUTPUTC_OREG_EN
        check("ovalid", {31'd0, ovalid}, {31'd0, r_valid});
        check("odata", odata, r_data);
        check("ovch", {31'd0, ovch}, {31'd0, r_vch});
`else
        check("ovalid", {31'd0, ovalid}, {31'd0, xf});
        check("odata", odata, ed);
        check("ovch", {31'd0, ovch}, {31'd0, evc});
`endif
        s_grt = grt; s_ordy = ordy; s_olck = olck; s_ovalid = ovalid;
        s_xfer = (|(grt & iv)) ? 1 : 0;
        @(posedge clk);
        #1;
        if (xf) begin
            if (m_busy == 0 && ty == `TYPE_HEAD) begin
                m_busy = 1; m_owner = g; m_lck = '0; m_lck[vc[g]] = 1'b1;
            end else if ((m_busy != 0 && ty == `TYPE_TAIL) || (m_busy == 0 && ty == `TYPE_HEADTAIL)) begin
                m_busy = 0; m_lck = '0; m_rr = (g + 1) % 5;
            end
        end
        for (int v = 0; v < 2; v++) begin
            bit dec, ack;
            dec = xf && (int'(vc[g]) == v);
            ack = iack[v] && (m_cnt[v] < CREDIT);
            if (dec && !ack)      m_cnt[v] = m_cnt[v] - 1;
            else if (ack && !dec) m_cnt[v] = m_cnt[v] + 1;
        end
        r_data = ed; r_valid = xf; r_vch = evc;
    endtask

    // reset takes effect immediately, whatever the clock is doing; release lands just after a rising edge
    task automatic do_reset();
        #1 rst_ = 1'b1;
        #1;
        check("rst_grt", {27'd0, grt}, 32'd0);
        check("rst_ovalid", {31'd0, ovalid}, 32'd0);
        check("rst_odata", odata, 32'd0);
        check("rst_ovch", {31'd0, ovch}, 32'd0);
        check("rst_olck", {30'd0, olck}, 32'd0);
        clear_in();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_ = 1'b0;
        #1;
        check("rst_ordy", {30'd0, ordy}, 32'h3);
    endtask

    initial begin
        int n;
        logic [1:0] seq [4];
        clear_in();
        model_reset();

        // two single-flit packets from inputs 0 and 3, round-robin from 0
        do_reset();
        rq[0] = 1; pt[0] = 2; iv[0] = 1; d[0] = {`TYPE_HEADTAIL, 30'h0A0};
        rq[3] = 1; pt[3] = 2; iv[3] = 1; d[3] = {`TYPE_HEADTAIL, 30'h3A3};
        n = 0;
        step(); check("a_first_grt", {27'd0, s_grt}, 32'h01); n += int'(s_ovalid);
        rq[0] = 0; iv[0] = 0;
        step(); check("a_second_grt", {27'd0, s_grt}, 32'h08); n += int'(s_ovalid);
        rq[3] = 0; iv[3] = 0;
        step(); n += int'(s_ovalid);
        check("a_link_flits", n, 2);

        // four-flit packet from input 1 holds off input 4
        do_reset();
        seq = '{`TYPE_HEAD, `TYPE_DATA, `TYPE_DATA, `TYPE_TAIL};
        iack = 2'b01;
        rq[4] = 1; pt[4] = 2; iv[4] = 1; d[4] = {`TYPE_HEADTAIL, 30'h444};
        rq[1] = 1; pt[1] = 2; iv[1] = 1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            d[1] = {seq[i], 30'(i + 16)};
            step();
            check("b_grt4_held", {31'd0, s_grt[4]}, 32'd0);
            n += int'(s_olck[0]);
        end
        rq[1] = 0; iv[1] = 0;
        step(); check("b_grt4_after_tail", {31'd0, s_grt[4]}, 32'd1); n += int'(s_olck[0]);
        rq[4] = 0; iv[4] = 0;
        step(); n += int'(s_olck[0]);
        check("b_olck_cycles", n, 4);

        // credit exhaustion on VC1 and a single returned credit
        do_reset();
        rq[0] = 1; pt[0] = 2; iv[0] = 1; vc[0] = 1; d[0] = {`TYPE_HEADTAIL, 30'h111};
        n = 0;
        repeat (6) begin step(); n += s_xfer; end
        check("c_xfers", n, 4);
        check("c_ordy1_low", {31'd0, s_ordy[1]}, 32'd0);
        check("c_grt_low", {27'd0, s_grt}, 32'd0);
        iack = 2'b10;
        step();
        iack = 2'b00;
        n = 0;
        repeat (4) begin step(); n += s_xfer; end
        check("c_one_more", n, 1);

        // simultaneous transfer and iack at cnt 2, then saturation at CREDIT
        rq[0] = 0; iv[0] = 0;
        iack = 2'b10;
        step(); step();
        rq[0] = 1; iv[0] = 1;
        step();
        check("d_xfer_with_ack", {31'd0, s_grt[0]}, 32'd1);
        iack = 2'b00;
        n = 0;
        repeat (4) begin step(); n += s_xfer; end
        check("d_cnt_stays2", n, 2);
        rq[0] = 0; iv[0] = 0;
        iack = 2'b10;
        repeat (6) step();
        iack = 2'b00;
        rq[0] = 1; iv[0] = 1;
        n = 0;
        repeat (7) begin step(); n += s_xfer; end
        check("d_saturate", n, CREDIT);

        // reset mid-packet
        do_reset();
        rq[1] = 1; pt[1] = 2; iv[1] = 1; d[1] = {`TYPE_HEAD, 30'h5};
        step();
        check("e_head_lock", {31'd0, s_olck[0]}, 32'd1);
        d[1] = {`TYPE_DATA, 30'h6};
        do_reset();
        rq[4] = 1; pt[4] = 2; iv[4] = 1; d[4] = {`TYPE_HEADTAIL, 30'h7};
        step();
        check("e_idle_grant", {27'd0, s_grt}, 32'h10);

        // single-flit link latency
        do_reset();
        rq[2] = 1; pt[2] = 2; iv[2] = 1; d[2] = {`TYPE_HEADTAIL, 30'h2B};
        step();
        rq[2] = 0; iv[2] = 0;
`ifdef OUTPUTC_OREG_EN
        check("f_lat_t", {31'd0, s_ovalid}, 32'd0);
        step();
        check("f_lat_t1", {31'd0, s_ovalid}, 32'd1);
`else
        check("f_lat_t", {31'd0, s_ovalid}, 32'd1);
        step();
        check("f_lat_t1", {31'd0, s_ovalid}, 32'd0);
`endif

        // randomized traffic against the model
        do_reset();
        repeat (400) begin
            for (int i = 0; i < 5; i++) begin
                rq[i] = ($urandom_range(0, 2) != 0);
                pt[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 4)) : 3'd2;
                iv[i] = ($urandom_range(0, 3) != 0);
                vc[i] = 1'($urandom);
                d[i]  = $urandom;
            end
            iack = 2'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
